// File: rtl/img_ram_read_arbiter_pkg.sv
// Shared image-RAM types and constants for the draw, scan-out and read-arbiter blocks.
package img_ram_pkg;

  localparam int IMG_AW = 18;
  localparam int IMG_DW = 8;

  // Image header layout: 16-bit width and height, little-endian, then pixels.
  localparam logic [IMG_AW-1:0] HDR_WIDTH_LO  = 18'h00;
  localparam logic [IMG_AW-1:0] HDR_WIDTH_HI  = 18'h01;
  localparam logic [IMG_AW-1:0] HDR_HEIGHT_LO = 18'h02;
  localparam logic [IMG_AW-1:0] HDR_HEIGHT_HI = 18'h03;
  localparam logic [IMG_AW-1:0] PIX_BASE      = 18'h10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_SEC  = 2'd2
  } owner_t;

endpackage

// File: rtl/img_ram_read_arbiter_if.sv
// Bus bundle between the two image-RAM requesters, the RAM read port and the arbiter.
interface img_ram_read_arbiter_if
  import img_ram_pkg::*;
#(
    parameter int AW = IMG_AW,
    parameter int DW = IMG_DW
);
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          disp_miss;

    logic          sec_req;
    logic [AW-1:0] sec_addr;
    logic          sec_gnt;
    logic [DW-1:0] sec_rdata;
    logic          sec_rvalid;

    logic [15:0]   miss_cnt;
    logic          miss_clr;

    logic [AW-1:0] ram_rdaddress;
    logic [DW-1:0] ram_q;

    modport slave (
        input  disp_req, disp_addr, sec_req, sec_addr, miss_clr, ram_q,
        output disp_rdata, disp_rvalid, disp_miss, sec_gnt, sec_rdata, sec_rvalid,
               miss_cnt, ram_rdaddress
    );

    modport master (
        output disp_req, disp_addr, sec_req, sec_addr, miss_clr, ram_q,
        input  disp_rdata, disp_rvalid, disp_miss, sec_gnt, sec_rdata, sec_rvalid,
               miss_cnt, ram_rdaddress
    );
endinterface

// File: rtl/img_ram_read_arbiter_rd_tag_pipe.sv
// Owner-tag delay line: tracks who issued each RAM read until its data returns.
module rd_tag_pipe
  import img_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t i_tag,
    output owner_t o_tag
);
    owner_t r_pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= OWN_NONE;
        end else begin
            r_pipe[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/img_ram_read_arbiter.sv
// Image-RAM read port arbiter: display has priority, secondary master gets idle
// slots and, after MAX_WAIT stalled cycles, steals one display slot.
module img_ram_read_arbiter
  import img_ram_pkg::*;
#(
    parameter int AW       = IMG_AW,
    parameter int DW       = IMG_DW,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 64
) (
    input logic             clk,
    input logic             rst,
    img_ram_read_arbiter_if.slave bus
);
    localparam int            WW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [WW-1:0] r_wait_cnt;
    logic [AW-1:0] r_rdaddr;
    logic [DW-1:0] r_disp_rdata;
    logic [DW-1:0] r_sec_rdata;
    logic          r_disp_rvalid;
    logic          r_sec_rvalid;
    logic [15:0]   r_miss_cnt;

    owner_t w_sel;
    owner_t w_tag_out;
    logic   w_force;
    logic   w_miss;
    logic   w_gnt;

    // Grants are gated by reset so a request held through reset is re-arbitrated.
    always_comb begin
        w_force = 1'b0;
        w_sel   = OWN_NONE;
        if (!rst) begin
            w_force = bus.sec_req && (MAX_WAIT != 0) && (r_wait_cnt == WMAX);
            if (w_force)           w_sel = OWN_SEC;
            else if (bus.disp_req) w_sel = OWN_DISP;
            else if (bus.sec_req)  w_sel = OWN_SEC;
        end
    end

    assign w_gnt  = (w_sel == OWN_SEC);
    assign w_miss = w_force && bus.disp_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_rdaddr <= '0;
        else if (w_sel == OWN_DISP) r_rdaddr <= bus.disp_addr;
        else if (w_sel == OWN_SEC)  r_rdaddr <= bus.sec_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (bus.sec_req && !w_gnt) begin
            if (r_wait_cnt != WMAX) r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    rd_tag_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .i_tag(w_sel),
        .o_tag(w_tag_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_rdata  <= '0;
            r_sec_rdata   <= '0;
            r_disp_rvalid <= 1'b0;
            r_sec_rvalid  <= 1'b0;
        end else begin
            r_disp_rvalid <= (w_tag_out == OWN_DISP);
            r_sec_rvalid  <= (w_tag_out == OWN_SEC);
            if (w_tag_out == OWN_DISP) r_disp_rdata <= bus.ram_q;
            if (w_tag_out == OWN_SEC)  r_sec_rdata  <= bus.ram_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_miss_cnt <= '0;
        else if (bus.miss_clr)                    r_miss_cnt <= '0;
        else if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end

    assign bus.sec_gnt       = w_gnt;
    assign bus.disp_miss     = w_miss;
    assign bus.ram_rdaddress = r_rdaddr;
    assign bus.disp_rdata    = r_disp_rdata;
    assign bus.disp_rvalid   = r_disp_rvalid;
    assign bus.sec_rdata     = r_sec_rdata;
    assign bus.sec_rvalid    = r_sec_rvalid;
    assign bus.miss_cnt      = r_miss_cnt;
endmodule

// File: tb/tb_img_ram_read_arbiter.sv
// Scoreboard bench for img_ram_read_arbiter with RD_LAT=1, MAX_WAIT=4.
module tb_img_ram_read_arbiter;
    import img_ram_pkg::*;

    localparam int MW = 4;

    logic clk;
    logic rst;

    img_ram_read_arbiter_if #(.AW(18), .DW(8)) bus ();

    img_ram_read_arbiter #(
        .AW(18), .DW(8), .RD_LAT(1), .MAX_WAIT(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM, one cycle latency, contents = low address byte.
    always @(posedge clk) bus.ram_q <= bus.ram_rdaddress[7:0];

    typedef struct {
        owner_t     own;
        logic [7:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_chk;
    int          n_fail;
    int          m_wait;
    logic [15:0] m_mcnt;
    logic [7:0]  m_dd;
    logic [7:0]  m_sd;
    logic [17:0] m_raddr;

    task automatic model_reset();
        exp_t e;
        e.own  = OWN_NONE;
        e.data = 8'h00;
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(e);
        m_wait  = 0;
        m_mcnt  = '0;
        m_dd    = '0;
        m_sd    = '0;
        m_raddr = '0;
    endtask

    // Drives one cycle and returns what the outputs must show at this negedge.
    task automatic step(input logic dreq, input logic [17:0] daddr, input logic sreq,
                        input logic [17:0] saddr, input logic clr,
                        output logic e_gnt, output logic e_miss,
                        output logic e_dv, output logic [7:0] e_dd,
                        output logic e_sv, output logic [7:0] e_sd,
                        output logic [15:0] e_mcnt, output logic [17:0] e_raddr);
        exp_t e;
        exp_t n;
        logic frc;
        @(negedge clk);
        e = q.pop_front();
        if (e.own == OWN_DISP) m_dd = e.data;
        if (e.own == OWN_SEC)  m_sd = e.data;
        e_dv    = (e.own == OWN_DISP);
        e_sv    = (e.own == OWN_SEC);
        e_dd    = m_dd;
        e_sd    = m_sd;
        e_mcnt  = m_mcnt;
        e_raddr = m_raddr;
        bus.disp_req  = dreq;
        bus.disp_addr = daddr;
        bus.sec_req   = sreq;
        bus.sec_addr  = saddr;
        bus.miss_clr  = clr;
        #1;
        frc    = sreq && (m_wait == MW);
        e_gnt  = frc || (!dreq && sreq);
        e_miss = frc && dreq;
        n.own  = e_gnt ? OWN_SEC : (dreq ? OWN_DISP : OWN_NONE);
        n.data = e_gnt ? saddr[7:0] : daddr[7:0];
        q.push_back(n);
        if (e_gnt)     m_raddr = saddr;
        else if (dreq) m_raddr = daddr;
        m_wait = (sreq && !e_gnt) ? ((m_wait == MW) ? MW : m_wait + 1) : 0;
        if (clr)                            m_mcnt = '0;
        else if (e_miss && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.disp_req = 0; bus.disp_addr = '0; bus.sec_req = 0; bus.sec_addr = '0; bus.miss_clr = 0;
        #3;
        n_chk++;
        if ({bus.disp_rdata, bus.disp_rvalid, bus.disp_miss, bus.sec_gnt, bus.sec_rdata,
             bus.sec_rvalid, bus.miss_cnt, bus.ram_rdaddress} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got drd=%h dv=%b sv=%b srd=%h cnt=%h addr=%h want all 0",
                     bus.disp_rdata, bus.disp_rvalid, bus.sec_rvalid, bus.sec_rdata,
                     bus.miss_cnt, bus.ram_rdaddress);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_sec();
        logic eg, em, edv, esv; logic [7:0] edd, esd; logic [15:0] emc; logic [17:0] era;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 18'h0, (i == 0), 18'h10, 1'b0, eg, em, edv, edd, esv, esd, emc, era);
            n_chk++;
            if ({bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress} !== {eg, em, emc, era}) begin
                n_fail++;
                $display("FAIL single_ctl c%0d: got gnt=%b miss=%b cnt=%h addr=%h want %b %b %h %h",
                         i, bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress, eg, em, emc, era);
            end
            n_chk++;
            if ({bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata} !== {edv, edd, esv, esd}) begin
                n_fail++;
                $display("FAIL single_data c%0d: got dv=%b d=%h sv=%b s=%h want %b %h %b %h",
                         i, bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata, edv, edd, esv, esd);
            end
            if (i == 1) begin
                n_chk++;
                if (bus.ram_rdaddress !== 18'h10) begin
                    n_fail++;
                    $display("FAIL single_addr: got %h want 00010", bus.ram_rdaddress);
                end
            end
            if (i == 3) begin
                n_chk++;
                if ({bus.sec_rvalid, bus.sec_rdata} !== {1'b1, 8'h10}) begin
                    n_fail++;
                    $display("FAIL single_latency: got sv=%b s=%h want 1 10", bus.sec_rvalid, bus.sec_rdata);
                end
            end
        end
    endtask

    task automatic test_disp_stream();
        logic eg, em, edv, esv; logic [7:0] edd, esd; logic [15:0] emc; logic [17:0] era;
        int nv, nsv, first;
        nv = 0; nsv = 0; first = -1;
        for (int i = 0; i < 12; i++) begin
            step((i < 8), 18'(i), 1'b0, 18'h0, 1'b0, eg, em, edv, edd, esv, esd, emc, era);
            n_chk++;
            if ({bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress} !== {eg, em, emc, era}) begin
                n_fail++;
                $display("FAIL stream_ctl c%0d: got gnt=%b miss=%b cnt=%h addr=%h want %b %b %h %h",
                         i, bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress, eg, em, emc, era);
            end
            n_chk++;
            if ({bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata} !== {edv, edd, esv, esd}) begin
                n_fail++;
                $display("FAIL stream_data c%0d: got dv=%b d=%h sv=%b s=%h want %b %h %b %h",
                         i, bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata, edv, edd, esv, esd);
            end
            if (bus.disp_rvalid === 1'b1) begin
                if (first < 0) first = i;
                nv++;
            end
            if (bus.sec_rvalid === 1'b1) nsv++;
        end
        n_chk++;
        if (nv != 8 || first != 3 || nsv != 0) begin
            n_fail++;
            $display("FAIL stream_run: got count=%0d first=%0d sec=%0d want 8 3 0", nv, first, nsv);
        end
    endtask

    task automatic test_starvation();
        logic eg, em, edv, esv; logic [7:0] edd, esd; logic [15:0] emc; logic [17:0] era;
        logic g; int gidx, nmiss;
        g = 0; gidx = -1; nmiss = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 18'h20 + 18'(i), !g, 18'h55, 1'b0, eg, em, edv, edd, esv, esd, emc, era);
            n_chk++;
            if ({bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress} !== {eg, em, emc, era}) begin
                n_fail++;
                $display("FAIL starve_ctl c%0d: got gnt=%b miss=%b cnt=%h addr=%h want %b %b %h %h",
                         i, bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress, eg, em, emc, era);
            end
            n_chk++;
            if ({bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata} !== {edv, edd, esv, esd}) begin
                n_fail++;
                $display("FAIL starve_data c%0d: got dv=%b d=%h sv=%b s=%h want %b %h %b %h",
                         i, bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata, edv, edd, esv, esd);
            end
            if (i == 7) begin
                n_chk++;
                if ({bus.disp_rvalid, bus.sec_rvalid, bus.sec_rdata} !== {1'b0, 1'b1, 8'h55}) begin
                    n_fail++;
                    $display("FAIL starve_slot: got dv=%b sv=%b s=%h want 0 1 55",
                             bus.disp_rvalid, bus.sec_rvalid, bus.sec_rdata);
                end
            end
            if (bus.sec_gnt === 1'b1 && !g) begin gidx = i; g = 1; end
            if (bus.disp_miss === 1'b1) nmiss++;
        end
        n_chk++;
        if (gidx != 4 || nmiss != 1 || bus.miss_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL starve_grant: got gnt_cycle=%0d misses=%0d cnt=%0d want 4 1 1", gidx, nmiss, bus.miss_cnt);
        end
    endtask

    task automatic test_alternate();
        logic eg, em, edv, esv; logic [7:0] edd, esd; logic [15:0] emc; logic [17:0] era;
        int k, ngnt, nmiss, wmax;
        k = 0; ngnt = 0; nmiss = 0; wmax = 0;
        for (int i = 0; i < 12; i++) begin
            step((i % 2 == 0), 18'h100 + 18'(i), 1'b1, 18'h30 + 18'(k), 1'b0,
                 eg, em, edv, edd, esv, esd, emc, era);
            n_chk++;
            if ({bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress} !== {eg, em, emc, era}) begin
                n_fail++;
                $display("FAIL alt_ctl c%0d: got gnt=%b miss=%b cnt=%h addr=%h want %b %b %h %h",
                         i, bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress, eg, em, emc, era);
            end
            n_chk++;
            if ({bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata} !== {edv, edd, esv, esd}) begin
                n_fail++;
                $display("FAIL alt_data c%0d: got dv=%b d=%h sv=%b s=%h want %b %h %b %h",
                         i, bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata, edv, edd, esv, esd);
            end
            if (bus.sec_gnt === 1'b1) begin ngnt++; k++; end
            if (bus.disp_miss === 1'b1) nmiss++;
            if (int'(dut.r_wait_cnt) > wmax) wmax = int'(dut.r_wait_cnt);
        end
        n_chk++;
        if (ngnt != 6 || nmiss != 0 || wmax >= MW) begin
            n_fail++;
            $display("FAIL alt_fair: got grants=%0d misses=%0d max_wait=%0d want 6 0 <4", ngnt, nmiss, wmax);
        end
    endtask

    task automatic test_reset_midflight();
        logic eg, em, edv, esv; logic [7:0] edd, esd; logic [15:0] emc; logic [17:0] era;
        int nv;
        step(1'b1, 18'h41, 1'b0, 18'h0, 1'b0, eg, em, edv, edd, esv, esd, emc, era);
        step(1'b1, 18'h42, 1'b1, 18'h66, 1'b0, eg, em, edv, edd, esv, esd, emc, era);
        #1;
        bus.disp_req = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.disp_rdata, bus.disp_rvalid, bus.disp_miss, bus.sec_gnt, bus.sec_rdata,
             bus.sec_rvalid, bus.miss_cnt, bus.ram_rdaddress} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got drd=%h dv=%b gnt=%b srd=%h sv=%b cnt=%h addr=%h want all 0",
                     bus.disp_rdata, bus.disp_rvalid, bus.sec_gnt, bus.sec_rdata, bus.sec_rvalid,
                     bus.miss_cnt, bus.ram_rdaddress);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 18'h0, (i == 0), 18'h66, 1'b0, eg, em, edv, edd, esv, esd, emc, era);
            n_chk++;
            if ({bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress} !== {eg, em, emc, era}) begin
                n_fail++;
                $display("FAIL rst_ctl c%0d: got gnt=%b miss=%b cnt=%h addr=%h want %b %b %h %h",
                         i, bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress, eg, em, emc, era);
            end
            n_chk++;
            if ({bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata} !== {edv, edd, esv, esd}) begin
                n_fail++;
                $display("FAIL rst_data c%0d: got dv=%b d=%h sv=%b s=%h want %b %h %b %h",
                         i, bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata, edv, edd, esv, esd);
            end
            if (bus.disp_rvalid === 1'b1) nv++;
        end
        n_chk++;
        if (nv != 0 || bus.sec_rdata !== 8'h66) begin
            n_fail++;
            $display("FAIL rst_flush: got stale_dv=%0d srd=%h want 0 66", nv, bus.sec_rdata);
        end
    endtask

    task automatic test_miss_sat();
        logic eg, em, edv, esv; logic [7:0] edd, esd; logic [15:0] emc; logic [17:0] era;
        logic g;
        force dut.r_miss_cnt = 16'hFFFF;
        #1;
        release dut.r_miss_cnt;
        m_mcnt = 16'hFFFF;
        for (int pass = 0; pass < 2; pass++) begin
            g = 0;
            for (int i = 0; i < 7; i++) begin
                step(1'b1, 18'(i), !g && (i < 6), 18'h77, (pass == 1) && (i == 4),
                     eg, em, edv, edd, esv, esd, emc, era);
                n_chk++;
                if ({bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress} !== {eg, em, emc, era}) begin
                    n_fail++;
                    $display("FAIL sat_ctl p%0d c%0d: got gnt=%b miss=%b cnt=%h addr=%h want %b %b %h %h",
                             pass, i, bus.sec_gnt, bus.disp_miss, bus.miss_cnt, bus.ram_rdaddress, eg, em, emc, era);
                end
                n_chk++;
                if ({bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata} !== {edv, edd, esv, esd}) begin
                    n_fail++;
                    $display("FAIL sat_data p%0d c%0d: got dv=%b d=%h sv=%b s=%h want %b %h %b %h",
                             pass, i, bus.disp_rvalid, bus.disp_rdata, bus.sec_rvalid, bus.sec_rdata, edv, edd, esv, esd);
                end
                if (i == 4) begin
                    n_chk++;
                    if (bus.disp_miss !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sat_pulse p%0d: got miss=%b want 1", pass, bus.disp_miss);
                    end
                end
                if (bus.sec_gnt === 1'b1) g = 1;
            end
            n_chk++;
            if (bus.miss_cnt !== ((pass == 0) ? 16'hFFFF : 16'h0000)) begin
                n_fail++;
                $display("FAIL sat_cnt p%0d: got %h want %h", pass, bus.miss_cnt,
                         (pass == 0) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_single_sec();
        test_disp_stream();
        test_starvation();
        test_alternate();
        test_reset_midflight();
        test_miss_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/img_ram_read_arbiter.md
Name: img_ram_read_arbiter

Overview:
- Shares the single read port of the grayscale image RAM between two requesters.
- Requester one is the VGA pixel fetch path: high priority, one read per pixel clock during active video.
- Requester two is a secondary master, such as the processing core or the header/debug reader: low priority, req/gnt handshake.
- Tags every issued read with its owner and routes the returning ram_q to the correct requester after a fixed RAM latency.
- A starvation guard lets the secondary master steal one display slot after waiting MAX_WAIT cycles; each stolen slot is flagged to the display.

Parameters:
- AW, 18, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, cycles from ram_rdaddress change to valid ram_q. Legal range 1..4.
- MAX_WAIT, 64, consecutive cycles the secondary master may wait before a forced grant. 0 disables forcing.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous, active-high reset
- disp_req  in  1  display requests a read this cycle (no grant; accepted unless stolen)
- disp_addr  in  AW  display read address
- disp_rdata  out  DW  display read data
- disp_rvalid  out  1  disp_rdata valid this cycle
- disp_miss  out  1  one-cycle pulse: this cycle's display request was dropped for a forced secondary grant
- sec_req  in  1  secondary master read request; hold with sec_addr stable until sec_gnt
- sec_addr  in  AW  secondary read address
- sec_gnt  out  1  combinational; request accepted at this clock edge
- sec_rdata  out  DW  secondary read data
- sec_rvalid  out  1  sec_rdata valid this cycle
- miss_cnt  out  16  saturating count of disp_miss pulses
- miss_clr  in  1  synchronous clear of miss_cnt
- ram_rdaddress  out  AW  registered RAM read address
- ram_q  in  DW  RAM read data

Behaviour:
- Reset values: all outputs 0; tag pipeline cleared; starvation counter 0.
- Arbitration is evaluated every cycle. "force" = sec_req && MAX_WAIT!=0 && wait_cnt==MAX_WAIT.
  - force: grant secondary; disp_miss=disp_req.
  - else disp_req: grant display.
  - else sec_req: grant secondary.
  - else idle: ram_rdaddress holds its last value; a NONE tag is issued.
- sec_gnt = secondary selected this cycle. It is combinational from sec_req, disp_req and wait_cnt.
- At the edge ending a granted cycle:
  - ram_rdaddress <= the granted address.
  - Owner tag pushed into a shift pipe of depth RD_LAT+1.
- Pipe output routing:
  - Tag DISP: disp_rdata <= ram_q, disp_rvalid=1.
  - Tag SEC: sec_rdata <= ram_q, sec_rvalid=1.
  - Tag NONE: both rvalid 0.
  - rdata registers hold their value when not updated.
- Latency: rvalid rises exactly RD_LAT+1 cycles after the accepting edge.
  - Back-to-back requests give back-to-back rvalids, in order.
  - Both rvalids are never high in the same cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle sec_req=1 && !sec_gnt.
  - Cleared on sec_gnt or when sec_req=0.
- miss_cnt:
  - +1 per disp_miss, saturating at 16'hFFFF.
  - miss_clr has priority over an increment in the same cycle.
- Display during blanking drives disp_req=0, so the secondary master gets every slot.
- Reset mid-operation: in-flight reads are discarded and no rvalid is generated for them. A sec_req held through reset must be re-arbitrated.
- Simultaneous force and miss_clr: miss_cnt becomes 0 and disp_miss still pulses.

Decomposition:
- Package img_ram_pkg:
  - enum owner_t {OWN_NONE, OWN_DISP, OWN_SEC}.
  - Constants IMG_AW=18 and IMG_DW=8, shared with draw/scan-out blocks.
  - Header-offset constants (width/height bytes, pixel base 18'h10).
- Sub-module rd_tag_pipe: parameterized-depth shift register of owner_t. Reset clears it to OWN_NONE.

Test Plan:
- RD_LAT=1, only sec_req with sec_addr=18'h10 and a RAM model returning addr[7:0]:
  - sec_gnt is high the same cycle.
  - ram_rdaddress=18'h10 next cycle.
  - sec_rvalid with sec_rdata=8'h10 two cycles after acceptance.
- disp_req streaming addresses 0..7 continuously, sec_req=0:
  - disp_rvalid is high for 8 consecutive cycles with data 0..7 in order.
  - sec_rvalid stays 0.
- MAX_WAIT=4, disp_req always 1, sec_req held from cycle 0:
  - sec_gnt on cycle 4 exactly.
  - disp_miss pulses once and miss_cnt=1.
  - The display stream has one missing rvalid, and the sec data lands in the correct slot.
- Alternating disp_req 1/0 with sec_req always 1:
  - sec is granted on every disp-idle cycle.
  - wait_cnt never reaches 4 and disp_miss is never asserted.
- rst asserted for one cycle with 2 reads in flight:
  - No rvalid follows.
  - All outputs 0 immediately (async).
  - The next grant behaves as from power-up.
- miss_cnt preloaded to 16'hFFFF by forcing:
  - A further miss keeps it at 16'hFFFF.
  - miss_clr together with a miss gives 0.
